wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two result producers: the execute stage (exe) and the load/store unit (mem).
- Each source has a small FIFO queue. Each cycle the block grants one queue head and drives a registered write (address, data, enable) to the register file.
- Sits between the execute/memory stages and the register file, in place of a direct per-stage writeback connection.

---
 rtl/wb_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two per-source FIFOs (exe, mem) share one registered register-file write port.
// Optional WB_RR_ARB_EN swaps fixed mem>exe priority for a 1-bit round-robin pointer.

module wb_fifo #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [AW-1:0] i_rd,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_rd,
  output logic [DW-1:0] o_data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]              r_wptr, r_rptr;
  logic [PW:0]                r_count;
  logic [DEPTH-1:0][AW-1:0]   r_rd;
  logic [DEPTH-1:0][DW-1:0]   r_data;
  logic                       w_full, w_push, w_pop;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign o_ready = !i_rst && !w_full;
  assign o_valid = (r_count != '0);
  assign o_rd    = r_rd[r_rptr];
  assign o_data  = r_data[r_rptr];

  // rd==0 is acknowledged upstream but never stored, so x0 is never written
  assign w_push = i_push && !w_full && (i_rd != '0);
  assign w_pop  = i_pop && o_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= i_rd;
      r_data[r_wptr] <= i_data;
    end
  end
endmodule

module wb_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      exe_valid,
  input  logic [REG_ADDR_WIDTH-1:0] exe_rd,
  input  logic [DATA_WIDTH-1:0]     exe_data,
  output logic                      exe_ready,
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      mem_ready,
  output logic                      Wr_En,
  output logic [REG_ADDR_WIDTH-1:0] WrtBck_Addr,
  output logic [DATA_WIDTH-1:0]     WrtBck_Data,
  output logic                      conflict
);
  localparam int NSRC = 2;  // index 0 = exe, 1 = mem

  logic [NSRC-1:0]                     w_in_vld, w_rdy, w_hvld, w_pop;
  logic [NSRC-1:0][REG_ADDR_WIDTH-1:0] w_in_rd, w_hrd;
  logic [NSRC-1:0][DATA_WIDTH-1:0]     w_in_data, w_hdata;
  logic                                w_both, w_gnt_mem, w_gnt_exe;

  assign w_in_vld  = {mem_valid, exe_valid};
  assign w_in_rd   = {mem_rd, exe_rd};
  assign w_in_data = {mem_data, exe_data};
  assign exe_ready = w_rdy[0];
  assign mem_ready = w_rdy[1];

  for (genvar g = 0; g < NSRC; g++) begin : g_q
    wb_fifo #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_q (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_push (w_in_vld[g]),
      .i_rd   (w_in_rd[g]),
      .i_data (w_in_data[g]),
      .i_pop  (w_pop[g]),
      .o_ready(w_rdy[g]),
      .o_valid(w_hvld[g]),
      .o_rd   (w_hrd[g]),
      .o_data (w_hdata[g])
    );
  end

  assign w_both = &w_hvld;

`ifdef WB_RR_ARB_EN
  logic r_prio_mem;

  assign w_gnt_mem = w_hvld[1] && (!w_hvld[0] || r_prio_mem);

  // pointer only moves on contended grants
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_prio_mem <= 1'b1;
    else if (w_both) r_prio_mem <= !r_prio_mem;
  end
`else
  assign w_gnt_mem = w_hvld[1];
`endif

  assign w_gnt_exe = w_hvld[0] && !w_gnt_mem;
  assign w_pop     = {w_gnt_mem, w_gnt_exe};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Wr_En       <= 1'b0;
      WrtBck_Addr <= '0;
      WrtBck_Data <= '0;
      conflict    <= 1'b0;
    end else begin
      Wr_En    <= |w_hvld;
      conflict <= w_both;
      if (w_gnt_mem) begin
        WrtBck_Addr <= w_hrd[1];
        WrtBck_Data <= w_hdata[1];
      end else if (w_gnt_exe) begin
        WrtBck_Addr <= w_hrd[0];
        WrtBck_Data <= w_hdata[0];
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes queued as stimulus is driven, compared against observed writes.
// Build with +define+WB_RR_ARB_EN to run the round-robin scenario instead of the fixed-priority starvation one.

module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          exe_valid, mem_valid, exe_ready, mem_ready;
  logic [AW-1:0] exe_rd, mem_rd, WrtBck_Addr;
  logic [DW-1:0] exe_data, mem_data, WrtBck_Data;
  logic          Wr_En, conflict;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } wb_t;

  wb_t exp_q[$];
  wb_t obs_q[$];
  wb_t e, o;
  int  pass_cnt = 0;
  int  tot_cnt  = 0;
  int  conf_cnt = 0;

  wb_port_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_data(exe_data), .exe_ready(exe_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .Wr_En(Wr_En), .WrtBck_Addr(WrtBck_Addr), .WrtBck_Data(WrtBck_Data), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic idle();
    exe_valid = 1'b0; exe_rd = '0; exe_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  // one clock; records any write and conflict seen after the edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (Wr_En === 1'b1) obs_q.push_back('{WrtBck_Addr, WrtBck_Data});
    if (conflict === 1'b1) conf_cnt++;
  endtask

  task automatic sb_clear();
    exp_q.delete(); obs_q.delete(); conf_cnt = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1;
    repeat (2) @(negedge clk);
    tot_cnt++; if (exe_ready !== 1'b0) $display("FAIL rst_exe_ready_in_reset got=%b exp=0", exe_ready); else pass_cnt++;
    reset = 1'b0; #1;
    tot_cnt++; if (Wr_En !== 1'b0) $display("FAIL rst_wr_en got=%b exp=0", Wr_En); else pass_cnt++;
    tot_cnt++; if (WrtBck_Addr !== '0) $display("FAIL rst_addr got=%0d exp=0", WrtBck_Addr); else pass_cnt++;
    tot_cnt++; if (WrtBck_Data !== '0) $display("FAIL rst_data got=%h exp=0", WrtBck_Data); else pass_cnt++;
    tot_cnt++; if (conflict !== 1'b0) $display("FAIL rst_conflict got=%b exp=0", conflict); else pass_cnt++;
    tot_cnt++; if ({exe_ready, mem_ready} !== 2'b11) $display("FAIL rst_ready got=%b exp=11", {exe_ready, mem_ready}); else pass_cnt++;
  endtask

  task automatic test_single_exe();
    sb_clear();
    exe_valid = 1'b1; exe_rd = 5'd5; exe_data = 32'h0000_00AA;
    exp_q.push_back('{5'd5, 32'h0000_00AA});
    tick();
    idle();
    tot_cnt++; if (Wr_En !== 1'b0) $display("FAIL single_no_bypass got=%b exp=0", Wr_En); else pass_cnt++;
    tick();
    tot_cnt++; if (Wr_En !== 1'b1) $display("FAIL single_wr_en got=%b exp=1", Wr_En); else pass_cnt++;
    tick();
    tot_cnt++; if (Wr_En !== 1'b0) $display("FAIL single_one_pulse got=%b exp=0", Wr_En); else pass_cnt++;
    tot_cnt++; if (WrtBck_Addr !== 5'd5) $display("FAIL single_addr_hold got=%0d exp=5", WrtBck_Addr); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL single_sb missing rd=%0d data=%h", e.rd, e.d);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL single_sb got rd=%0d data=%h exp rd=%0d data=%h", o.rd, o.d, e.rd, e.d); else pass_cnt++;
      end
    end
    tot_cnt++; if (obs_q.size() != 0) $display("FAIL single_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
    tot_cnt++; if (conf_cnt != 0) $display("FAIL single_conflict got=%0d exp=0", conf_cnt); else pass_cnt++;
  endtask

  task automatic test_conflict();
    sb_clear();
    exe_valid = 1'b1; exe_rd = 5'd3; exe_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h22;
    exp_q.push_back('{5'd7, 32'h22});
    exp_q.push_back('{5'd3, 32'h11});
    tick();
    idle();
    tick();
    tot_cnt++; if (conflict !== 1'b1) $display("FAIL conf_flag got=%b exp=1", conflict); else pass_cnt++;
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL conf_sb missing rd=%0d data=%h", e.rd, e.d);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL conf_sb got rd=%0d data=%h exp rd=%0d data=%h", o.rd, o.d, e.rd, e.d); else pass_cnt++;
      end
    end
    tot_cnt++; if (obs_q.size() != 0) $display("FAIL conf_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
    tot_cnt++; if (conf_cnt != 1) $display("FAIL conf_cycles got=%0d exp=1", conf_cnt); else pass_cnt++;
  endtask

  task automatic test_mem_priority();
    wb_t ex[2];
    sb_clear();
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(8 + i); mem_data = 32'hB000_0000 + 32'(i);
      exp_q.push_back('{5'(8 + i), 32'hB000_0000 + 32'(i)});
      if (i < 2) begin
        exe_valid = 1'b1; exe_rd = 5'(20 + i); exe_data = 32'hE000_0000 + 32'(i);
        ex[i] = '{5'(20 + i), 32'hE000_0000 + 32'(i)};
      end else begin
        exe_valid = 1'b0;
      end
      if (i == 2 || i == 5) begin
        tot_cnt++; if (exe_ready !== 1'b0) $display("FAIL prio_exe_full_ready it=%0d got=%b exp=0", i, exe_ready); else pass_cnt++;
        tot_cnt++; if (mem_ready !== 1'b1) $display("FAIL prio_mem_ready it=%0d got=%b exp=1", i, mem_ready); else pass_cnt++;
      end
      tick();
    end
    idle();
    exp_q.push_back(ex[0]);
    exp_q.push_back(ex[1]);
    repeat (5) tick();
    tot_cnt++; if (exe_ready !== 1'b1) $display("FAIL prio_exe_drained got=%b exp=1", exe_ready); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL prio_sb missing rd=%0d data=%h", e.rd, e.d);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL prio_sb got rd=%0d data=%h exp rd=%0d data=%h", o.rd, o.d, e.rd, e.d); else pass_cnt++;
      end
    end
    tot_cnt++; if (obs_q.size() != 0) $display("FAIL prio_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
    tot_cnt++; if (conf_cnt != 6) $display("FAIL prio_conflict_cycles got=%0d exp=6", conf_cnt); else pass_cnt++;
  endtask

  task automatic test_x0_drop();
    sb_clear();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
    tot_cnt++; if (mem_ready !== 1'b1) $display("FAIL x0_ready got=%b exp=1", mem_ready); else pass_cnt++;
    tick();
    idle();
    repeat (3) tick();
    tot_cnt++; if (obs_q.size() != 0) $display("FAIL x0_write got=%0d exp=0", obs_q.size()); else pass_cnt++;
    tot_cnt++; if (mem_ready !== 1'b1) $display("FAIL x0_ready_after got=%b exp=1", mem_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    sb_clear();
    for (int i = 0; i < 2; i++) begin
      exe_valid = 1'b1; exe_rd = 5'(12 + i); exe_data = 32'hE100_0000 + 32'(i);
      mem_valid = 1'b1; mem_rd = 5'(16 + i); mem_data = 32'hB100_0000 + 32'(i);
      tick();
    end
    idle();
    exp_q.push_back('{5'd16, 32'hB100_0000});
    tot_cnt++; if (exe_ready !== 1'b0) $display("FAIL rmid_filled got=%b exp=0", exe_ready); else pass_cnt++;
    reset = 1'b1; #1;
    tot_cnt++; if (Wr_En !== 1'b0) $display("FAIL rmid_wr_en got=%b exp=0", Wr_En); else pass_cnt++;
    tot_cnt++; if (conflict !== 1'b0) $display("FAIL rmid_conflict got=%b exp=0", conflict); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; #1;
    tot_cnt++; if ({exe_ready, mem_ready} !== 2'b11) $display("FAIL rmid_ready got=%b exp=11", {exe_ready, mem_ready}); else pass_cnt++;
    repeat (4) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL rmid_sb missing rd=%0d data=%h", e.rd, e.d);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL rmid_sb got rd=%0d data=%h exp rd=%0d data=%h", o.rd, o.d, e.rd, e.d); else pass_cnt++;
      end
    end
    tot_cnt++; if (obs_q.size() != 0) $display("FAIL rmid_stale got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

`ifdef WB_RR_ARB_EN
  task automatic test_round_robin();
    int  ae, am;
    logic er, mr;
    sb_clear();
    ae = 0; am = 0;
    for (int i = 0; i < 8; i++) begin
      exe_valid = 1'b1; exe_rd = 5'(1 + ae); exe_data = 32'hE000_0000 + 32'(ae);
      mem_valid = 1'b1; mem_rd = 5'(1 + am); mem_data = 32'hB000_0000 + 32'(am);
      er = exe_ready; mr = mem_ready;
      tick();
      if (er) ae++;
      if (mr) am++;
      if (i > 0) begin
        tot_cnt++; if (conflict !== 1'b1) $display("FAIL rr_conflict it=%0d got=%b exp=1", i, conflict); else pass_cnt++;
      end
    end
    idle();
    for (int k = 0; k < 16; k++) begin
      if (k < am) exp_q.push_back('{5'(1 + k), 32'hB000_0000 + 32'(k)});
      if (k < ae) exp_q.push_back('{5'(1 + k), 32'hE000_0000 + 32'(k)});
    end
    repeat (10) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL rr_sb missing rd=%0d data=%h", e.rd, e.d);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL rr_sb got rd=%0d data=%h exp rd=%0d data=%h", o.rd, o.d, e.rd, e.d); else pass_cnt++;
      end
    end
    tot_cnt++; if (obs_q.size() != 0) $display("FAIL rr_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask
`endif

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_single_exe();
    test_conflict();
`ifdef WB_RR_ARB_EN
    test_round_robin();
`else
    test_mem_priority();
`endif
    test_x0_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
